mdu: RTL

Iterative multiply/divide unit in the EX stage, alongside the ALU. It takes the same A/B operand buses that the ALU consumes.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the 64-bit result in the HI/LO architectural registers.
- Handles MTHI/MTLO in one cycle.
- Drives `busy` so the hazard unit stalls any MD-class instruction (including MFHI/MFLO) until the result is written.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_div_core.sv | 48 ++++
 rtl/mdu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, latencies.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int DIV_ITERS = 32;
  localparam int DIV_LAT   = DIV_ITERS + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL      = 2'd1,
    ST_DIV_ITER = 2'd2,
    ST_DIV_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned 32/32 restoring divider, one quotient bit per step.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic [32:0] shifted;
  logic [32:0] trial;

  // Partial remainder stays below the divisor, so bit 32 of trial is its sign.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
    end else if (step) begin
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit holding the HI/LO registers; busy stalls MD-class instructions.
//   state       | meaning
//   ST_IDLE     | accepts start; MTHI/MTLO complete here in one cycle
//   ST_MUL      | down-counts MUL_LAT cycles, then writes the held product
//   ST_DIV_ITER | 32 restoring divide steps
//   ST_DIV_FIX  | applies signs / divide-by-zero result and writes back
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MUL_TC_LOAD = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_TC_LOAD = 5'(DIV_ITERS - 1);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        accept, is_mul, is_div;
  logic        div_load, div_step, wb_mul, wb_div;
  logic        sgn_mul, neg_a, neg_b;
  logic [63:0] prod_d, prod_q;
  logic [31:0] dividend_q;
  logic        neg_quo_q, neg_rem_q, div_zero_q;
  logic        done_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] quo, rem;

  assign accept  = start && (state_q == ST_IDLE);
  assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div  = (op == MD_DIV)  || (op == MD_DIVU);
  assign sgn_mul = (op == MD_MULT);
  assign neg_a   = (op == MD_DIV) && A[31];
  assign neg_b   = (op == MD_DIV) && B[31];

  // Low 64 bits of a 64x64 product of the extended operands give the signed/unsigned result.
  assign prod_d = {{32{sgn_mul & A[31]}}, A} * {{32{sgn_mul & B[31]}}, B};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_load = 1'b0;
    div_step = 1'b0;
    wb_mul   = 1'b0;
    wb_div   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_d = ST_MUL;
          cnt_d   = MUL_TC_LOAD;
        end else if (accept && is_div) begin
          state_d  = ST_DIV_ITER;
          cnt_d    = DIV_TC_LOAD;
          div_load = 1'b1;
        end
      end
      ST_MUL: begin
        if (cnt_q == 5'd0) begin
          wb_mul  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DIV_ITER: begin
        div_step = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = ST_DIV_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DIV_FIX: begin
        wb_div  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mdu_div_core u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (neg_if(neg_a, A)),
    .divisor   (neg_if(neg_b, B)),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q     <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= wb_mul || wb_div;
      if (accept && is_mul) begin
        prod_q <= prod_d;
      end
      if (accept && is_div) begin
        dividend_q <= A;
        neg_quo_q  <= neg_a ^ neg_b;
        neg_rem_q  <= neg_a;
        div_zero_q <= (B == 32'd0);
      end
      if (accept && op == MD_MTHI) begin
        hi_q <= A;
      end
      if (accept && op == MD_MTLO) begin
        lo_q <= A;
      end
      if (wb_mul) begin
        hi_q <= prod_q[63:32];
        lo_q <= prod_q[31:0];
      end
      if (wb_div) begin
        if (div_zero_q) begin
          hi_q <= dividend_q;
          lo_q <= 32'hFFFF_FFFF;
        end else begin
          hi_q <= neg_if(neg_rem_q, rem);
          lo_q <= neg_if(neg_quo_q, quo);
        end
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
